prio_encoder_pipe: RTL and testbench
====================================

// Module: prio_encoder_pipe
// PURPOSE
//  Parametrised, registered N-to-log2(N) encoder with valid/ready handshake.
//  Successor to the fixed 8x3 combinational encoder: adds selectable LSB/MSB
//  priority or strict one-hot mode, hit/error flags and a saturating error counter.
//  Sits between request-vector producers (IRQ lines, arbiter grants) and index consumers.
// PARAMETERS
//  N          8   input vector width, >=2
//  W          $clog2(N)  output index width (localparam, derived, not overridable)
//  MODE       0   0=LSB-first priority, 1=MSB-first priority, 2=strict one-hot
//  ERR_CNT_W  8   width of saturating error counter
// PORTS
//  clk        in   1     clock, all logic on rising edge
//  rst_n      in   1     synchronous reset, active-low
//  in_valid   in   1     input vector valid
//  in_ready   out  1     block can accept input this cycle
//  in_vec     in   N     request / one-hot vector
//  out_valid  out  1     encoded result valid
//  out_ready  in   1     downstream accepts result
//  out_idx    out  W     encoded index
//  out_hit    out  1     at least one in_vec bit was set
//  out_err    out  1     invalid input for current MODE
//  clr_err    in   1     synchronous clear of err_count
//  err_count  out  ERR_CNT_W  number of accepted beats with out_err=1, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//  - out_valid=0, out_idx=0, out_hit=0, out_err=0, err_count=0.
//  - Any held result is discarded; applies mid-operation too.
//  Handshake:
//  - in_ready = !out_valid || out_ready (combinational; one-deep output register).
//  - Accept when in_valid && in_ready. Result appears on the next edge: latency 1 cycle.
//  - Back-to-back accepts at full rate while out_ready=1.
//  - While out_valid && !out_ready: out_idx/out_hit/out_err held stable; in_ready=0.
//  - out_valid clears after out_valid && out_ready with no new accept the same cycle.
//  - in_vec sampled only on accept.
//  Encoding (on accepted vector v):
//  - MODE 0: out_idx = index of lowest set bit.
//  - MODE 1: out_idx = index of highest set bit.
//  - In MODE 0/1: out_hit=|v; out_err=0.
//  - MODE 2, exactly one bit set: out_idx = that index; out_hit=1; out_err=0.
//  - MODE 2, zero bits set: out_idx=0; out_hit=0; out_err=1.
//  - MODE 2, multiple bits set: out_idx=0; out_hit=1; out_err=1.
//  - Any mode, v==0: out_idx=0, out_hit=0.
//  - N not a power of 2: indices >= N never produced.
//  Error counter:
//  - Increments by 1 on each accept whose computed out_err=1, i.e. on the edge the result is registered.
//  - Saturates at 2^ERR_CNT_W-1, never wraps.
//  - clr_err=1 sets the counter to 0. If an erroring accept occurs the same cycle, it becomes 1.
//  - rst_n overrides everything.
// TESTING
//  1. MODE=2, N=8: walk one-hot 0x01..0x80, out_ready=1 -> out_idx 0..7 one cycle after each accept; out_hit=1, out_err=0.
//  2. MODE=2: in_vec=0x00 then 0x12 -> out_idx=0; out_err=1 both; out_hit=0 then 1; err_count=2.
//  3. MODE=0 vs MODE=1, in_vec=0x12 -> out_idx=1 (MODE 0) / 4 (MODE 1); out_hit=1, out_err=0.
//  4. out_ready=0 for 3 cycles with result held, in_valid=1 -> in_ready=0, outputs stable.
//     Then out_ready=1 -> held beat drains, new beat accepted the same cycle; no loss, no duplication.
//  5. ERR_CNT_W=2, MODE=2: 5 erroring beats -> err_count saturates at 3.
//     clr_err together with an erroring accept -> err_count=1.
//  6. rst_n=0 for one cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_idx=0, err_count=0, in_ready=1.

Source files
------------

// File: rtl/prio_encoder_pipe.sv
// prio_encoder_pipe: registered N-to-$clog2(N) encoder with a valid/ready handshake.
// The modes are LSB-first priority, MSB-first priority and strict one-hot. The block
// reports hit and error flags, and keeps a saturating count of erroring beats.
// The output register is one beat deep. A new beat can be accepted in the same cycle
// that the held beat drains.
module prio_encoder_pipe #(
   parameter  int N         = 8,
   parameter  int MODE      = 0,
   parameter  int ERR_CNT_W = 8,
   localparam int W         = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_idx,
   output logic                 out_hit,
   output logic                 out_err,
   input  logic                 clr_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int MODE_LSB    = 0;
   localparam int MODE_MSB    = 1;
   localparam int MODE_ONEHOT = 2;

   logic         accept;
   logic [W-1:0] enc_idx;
   logic         enc_hit;
   logic         enc_err;
   logic         one_hot;

   // The output register can take a new beat when it is empty or when it drains this cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A vector is one-hot when it is nonzero and clearing its lowest set bit leaves zero.
   assign one_hot  = (in_vec != '0) && ((in_vec & (in_vec - N'(1))) == '0);

   // Combinational encoding of the presented vector for the selected mode.
   always_comb begin
      // NOTE: every output of this block gets a default before any branch, so no path
      // leaves a variable unassigned and no latch is inferred. Blocking '=' is correct
      // here: later loop iterations deliberately override earlier ones.
      enc_idx = '0;
      enc_hit = |in_vec;
      enc_err = 1'b0;
      case (MODE)
         MODE_MSB: begin
            // Ascending scan, so the last set bit found (the highest) wins.
            for (int i = 0; i < N; i++) begin
               if (in_vec[i]) enc_idx = W'(i);
            end
         end
         MODE_ONEHOT: begin
            if (one_hot) begin
               for (int i = 0; i < N; i++) begin
                  if (in_vec[i]) enc_idx = W'(i);
               end
            end else begin
               enc_err = 1'b1;
            end
         end
         default: begin
            // LSB-first. A descending scan means the lowest set bit wins.
            for (int i = N - 1; i >= 0; i--) begin
               if (in_vec[i]) enc_idx = W'(i);
            end
         end
      endcase
   end

   // Output register. It loads on accept, drains on out_ready, and holds while stalled.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<=' only, so every register samples
      // the values from before the edge. Reset is synchronous: it is checked inside the
      // clocked block, and it discards any held beat.
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_hit   <= 1'b0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_idx   <= enc_idx;
         out_hit   <= enc_hit;
         out_err   <= enc_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating error counter. A clear in the same cycle as an erroring accept leaves 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (clr_err) begin
         err_count <= (accept && enc_err) ? ERR_CNT_W'(1) : '0;
      end else if (accept && enc_err && (err_count != '1)) begin
         err_count <= err_count + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// tb_prio_encoder_pipe: directed bench with four encoder variants sharing one stimulus.
// The variants are LSB, MSB, one-hot with an 8-bit counter, and one-hot with a 2-bit counter.
module tb_prio_encoder_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_vec;
   logic       out_ready;
   logic       clr_err;

   logic       rdy_m0, rdy_m1, rdy_m2, rdy_s2;
   logic       vld_m0, vld_m1, vld_m2, vld_s2;
   logic [2:0] idx_m0, idx_m1, idx_m2, idx_s2;
   logic       hit_m0, hit_m1, hit_m2, hit_s2;
   logic       err_m0, err_m1, err_m2, err_s2;
   logic [7:0] cnt_m0, cnt_m1, cnt_m2;
   logic [1:0] cnt_s2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   prio_encoder_pipe #(.N(8), .MODE(0), .ERR_CNT_W(8)) u_m0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m0), .in_vec(in_vec),
      .out_valid(vld_m0), .out_ready(out_ready), .out_idx(idx_m0), .out_hit(hit_m0),
      .out_err(err_m0), .clr_err(clr_err), .err_count(cnt_m0));

   prio_encoder_pipe #(.N(8), .MODE(1), .ERR_CNT_W(8)) u_m1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m1), .in_vec(in_vec),
      .out_valid(vld_m1), .out_ready(out_ready), .out_idx(idx_m1), .out_hit(hit_m1),
      .out_err(err_m1), .clr_err(clr_err), .err_count(cnt_m1));

   prio_encoder_pipe #(.N(8), .MODE(2), .ERR_CNT_W(8)) u_m2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m2), .in_vec(in_vec),
      .out_valid(vld_m2), .out_ready(out_ready), .out_idx(idx_m2), .out_hit(hit_m2),
      .out_err(err_m2), .clr_err(clr_err), .err_count(cnt_m2));

   prio_encoder_pipe #(.N(8), .MODE(2), .ERR_CNT_W(2)) u_s2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s2), .in_vec(in_vec),
      .out_valid(vld_s2), .out_ready(out_ready), .out_idx(idx_s2), .out_hit(hit_s2),
      .out_err(err_s2), .clr_err(clr_err), .err_count(cnt_s2));

   // Single comparison point: counts every check and reports any mismatch.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks the full registered output of the one-hot instance with the 8-bit counter.
   task automatic chk_m2(input string tag, input int v, input int idx, input int hit, input int err);
      check({tag, "_m2_valid"}, 32'(vld_m2), v);
      check({tag, "_m2_idx"},   32'(idx_m2), idx);
      check({tag, "_m2_hit"},   32'(hit_m2), hit);
      check({tag, "_m2_err"},   32'(err_m2), err);
   endtask

   // Checks the LSB and MSB priority instances.
   task automatic chk_pri(input string tag, input int i0, input int i1, input int hit);
      check({tag, "_m0_idx"}, 32'(idx_m0), i0);
      check({tag, "_m1_idx"}, 32'(idx_m1), i1);
      check({tag, "_m0_hit"}, 32'(hit_m0), hit);
      check({tag, "_m1_hit"}, 32'(hit_m1), hit);
      check({tag, "_m0_err"}, 32'(err_m0), 0);
      check({tag, "_m1_err"}, 32'(err_m1), 0);
   endtask

   // Presents one vector with out_ready=1 and clocks it in.
   task automatic send(input logic [7:0] v);
      in_valid = 1'b1;
      in_vec   = v;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1; clr_err = 1'b0;
      #1;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state.
      chk_m2("rst", 0, 0, 0, 0);
      check("rst_m0_valid", 32'(vld_m0), 0);
      check("rst_m2_cnt",   32'(cnt_m2), 0);
      check("rst_s2_cnt",   32'(cnt_s2), 0);
      check("rst_m2_ready", 32'(rdy_m2), 1);

      // One-hot walk: each index appears one cycle after its accept.
      for (int i = 0; i < 8; i++) begin
         send(8'(1 << i));
         chk_m2($sformatf("walk%0d", i), 1, i, 1, 0);
         chk_pri($sformatf("walk%0d", i), i, i, 1);
      end
      check("walk_m2_cnt", 32'(cnt_m2), 0);

      // Zero vector and a multi-bit vector.
      send(8'h00);
      chk_m2("zero", 1, 0, 0, 1);
      chk_pri("zero", 0, 0, 0);
      send(8'h12);
      chk_m2("multi", 1, 0, 1, 1);
      chk_pri("p12", 1, 4, 1);
      check("multi_m2_cnt", 32'(cnt_m2), 2);
      check("multi_s2_cnt", 32'(cnt_s2), 2);

      // Extreme priority vectors and saturation of the 2-bit counter.
      send(8'h81);
      chk_pri("p81", 0, 7, 1);
      send(8'hFF);
      chk_pri("pFF", 0, 7, 1);
      check("sat4_s2_cnt", 32'(cnt_s2), 3);
      send(8'h03);
      chk_pri("p03", 0, 1, 1);
      check("sat5_m2_cnt", 32'(cnt_m2), 5);
      check("sat5_s2_cnt", 32'(cnt_s2), 3);

      // A clear together with an erroring accept leaves 1. With a clean accept it leaves 0.
      clr_err = 1'b1;
      send(8'h00);
      check("clr_err_m2_cnt", 32'(cnt_m2), 1);
      check("clr_err_s2_cnt", 32'(cnt_s2), 1);
      send(8'h04);
      check("clr_ok_m2_cnt", 32'(cnt_m2), 0);
      check("clr_ok_s2_cnt", 32'(cnt_s2), 0);
      clr_err = 1'b0;

      // Backpressure: the held beat stays stable, and in_vec changes are ignored while stalled.
      send(8'h20);
      out_ready = 1'b0;
      in_vec    = 8'h40;
      #1;
      check("stall_ready", 32'(rdy_m2), 0);
      for (int c = 0; c < 3; c++) begin
         if (c == 1) in_vec = 8'h02;
         tick();
         chk_m2($sformatf("stall%0d", c), 1, 5, 1, 0);
         check($sformatf("stall%0d_m0_idx", c), 32'(idx_m0), 5);
         check($sformatf("stall%0d_ready", c), 32'(rdy_m2), 0);
      end
      in_vec    = 8'h40;
      out_ready = 1'b1;
      #1;
      check("release_ready", 32'(rdy_m2), 1);
      tick();
      chk_m2("release", 1, 6, 1, 0);
      check("release_m1_idx", 32'(idx_m1), 6);
      in_valid = 1'b0;
      tick();
      check("drain_m2_valid", 32'(vld_m2), 0);
      check("drain_m0_valid", 32'(vld_m0), 0);
      check("drain_m2_idx",   32'(idx_m2), 6);
      out_ready = 1'b0;
      #1;
      check("empty_ready", 32'(rdy_m2), 1);
      tick();
      check("empty_stay_valid", 32'(vld_m2), 0);
      out_ready = 1'b1;

      // Reset while a beat is held under backpressure.
      send(8'h00);
      send(8'h08);
      chk_m2("pre_rst", 1, 3, 1, 0);
      check("pre_rst_m2_cnt", 32'(cnt_m2), 1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_m2("mid_rst", 0, 0, 0, 0);
      check("mid_rst_m1_idx", 32'(idx_m1), 0);
      check("mid_rst_m2_cnt", 32'(cnt_m2), 0);
      check("mid_rst_ready",  32'(rdy_m2), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
